// File: rtl/fp_to_linear.sv
// fp_to_linear: converts a tiny sign/exponent/significand float word
// (value = +/- F << E) into a 12-bit two's-complement linear value.
// The shift runs one bit per clock, so a conversion takes E+1 edges.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds S/E/F steady while in_valid=1 and in_ready=0.
// The consumer sees D stable while out_valid=1 until it raises out_ready.
module fp_to_linear (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] mag;
  logic [2:0]  cnt;
  logic        sgn;

  // Only IDLE accepts a word, so in_ready never depends on out_ready.
  assign in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd0)    state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per edge, then publish D.
  // mag is wide enough for 15<<7, so no set bit is ever shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag       <= 11'd0;
      cnt       <= 3'd0;
      sgn       <= 1'b0;
      D         <= 12'h000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag <= {7'd0, F};
            cnt <= E;
            sgn <= S;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end else begin
            // Negating zero gives zero, so S=1,F=0 cannot produce -0.
            D         <= sgn ? (12'd0 - {1'b0, mag}) : {1'b0, mag};
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_linear.sv
// Directed bench for fp_to_linear: fixed scenarios with hand-computed
// results, then a sweep over every {S,E,F} word against a small model.
module tb_fp_to_linear;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int n_checks = 0;
  int n_errors = 0;

  fp_to_linear dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // Reference model: +/- (F << E), wrapped to 12 bits.
  function automatic logic [11:0] ref_d(input logic s, input logic [2:0] e,
                                        input logic [3:0] f);
    int v;
    v = int'(f) << e;
    if (s) v = -v;
    return v[11:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word (waiting for in_ready), then count edges until
  // out_valid. Every waiting cycle must show in_ready=0. Optionally
  // completes the output handshake and checks the return to IDLE.
  task automatic convert(input logic s, input logic [2:0] e,
                         input logic [3:0] f, input bit release_out,
                         output logic [11:0] d, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    S = s; E = e; F = f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    S = 1'($urandom_range(0, 1));
    E = 3'($urandom_range(0, 7));
    F = 4'($urandom_range(0, 15));
    chk("in_ready_after_accept", in_ready, 0);
    chk("out_valid_after_accept", out_valid, 0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      if (out_valid) break;
    end
    d = D;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_out_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
      chk("release_d_kept", D, d);
    end
  endtask

  initial begin
    logic [11:0] d;
    int          lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    S = 1'b0; E = 3'd0; F = 4'd0;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", D, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Accept on the first edge after reset release; E=0 gives 1 edge.
    convert(1'b0, 3'd0, 4'h5, 1'b1, d, lat);
    chk("s1_d", d, 12'h005);
    chk("s1_lat", lat, 1);

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_out_ready_no_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    convert(1'b0, 3'd4, 4'h8, 1'b1, d, lat);
    chk("s2_d", d, 12'h080);
    chk("s2_lat", lat, 5);

    convert(1'b1, 3'd7, 4'hF, 1'b1, d, lat);
    chk("s3_d", d, 12'h880);
    chk("s3_lat", lat, 8);

    convert(1'b1, 3'd5, 4'h0, 1'b1, d, lat);
    chk("s4_d", d, 12'h000);
    chk("s4_lat", lat, 6);

    // Hold the output while a second word waits with in_valid=1.
    convert(1'b0, 3'd2, 4'h3, 1'b0, d, lat);
    chk("s5a_d", d, 12'h00C);
    chk("s5a_lat", lat, 3);
    in_valid = 1'b1; S = 1'b1; E = 3'd1; F = 4'h1;
    repeat (5) begin
      @(negedge clk);
      chk("s5_hold_d", D, 12'h00C);
      chk("s5_hold_in_ready", in_ready, 0);
      chk("s5_hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("s5_release_out_valid", out_valid, 0);
    chk("s5_release_in_ready", in_ready, 1);
    chk("s5_release_d", D, 12'h00C);
    convert(1'b1, 3'd1, 4'h1, 1'b1, d, lat);
    chk("s5b_d", d, 12'hFFE);
    chk("s5b_lat", lat, 2);

    // Reset two cycles into an E=6 conversion.
    in_valid = 1'b1; S = 1'b0; E = 3'd6; F = 4'h3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("s6_busy", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_out_valid", out_valid, 0);
    chk("s6_async_d", D, 12'h000);
    chk("s6_async_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("s6_no_stale_valid", out_valid, 0);
      chk("s6_idle_in_ready", in_ready, 1);
    end

    // Every word against the model.
    for (int w = 0; w < 256; w++) begin
      logic       ws;
      logic [2:0] we;
      logic [3:0] wf;
      ws = w[7];
      we = w[6:4];
      wf = w[3:0];
      convert(ws, we, wf, 1'b1, d, lat);
      chk($sformatf("sweep_d_%02h", w), d, ref_d(ws, we, wf));
      chk($sformatf("sweep_lat_%02h", w), lat, int'(we) + 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_to_linear.md
FP_TO_LINEAR -- requirements
Module: fp_to_linear

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  float word on S/E/F is valid.
REQ-005 in_ready  output  1  block can accept a float word.
REQ-006 S  input  1  sign of float word.
REQ-007 E  input  3  exponent of float word.
REQ-008 F  input  4  significand of float word.
REQ-009 out_valid  output  1  D holds a completed conversion.
REQ-010 out_ready  input  1  consumer accepts D.
REQ-011 D  output  12  two's-complement linear value.

Function
REQ-012 The block SHALL decode a float word as value = (S ? -1 : +1) * (F << E).
- Max magnitude: 15<<7 = 1920, which fits 12-bit signed; no saturation is needed.
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE; encoding is free.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE.
- No combinational path from out_ready to in_ready.
REQ-015 Accept SHALL occur on an edge where state is IDLE and in_valid is 1.
- Same edge: mag[10:0] <= zero-extended F; cnt[2:0] <= E; sgn <= S; state -> SHIFT.
REQ-016 S/E/F SHALL be sampled only on the accept edge.
- Changes at any other time have no effect.
REQ-017 In SHIFT with cnt != 0, each edge SHALL do mag <= mag << 1 and cnt <= cnt - 1.
REQ-018 In SHIFT with cnt == 0, the edge SHALL do D <= sgn ? (0 - {1'b0,mag}) : {1'b0,mag}.
- Same edge: out_valid <= 1; state -> DONE.
REQ-019 Latency: out_valid SHALL rise exactly E+1 edges after the accept edge (E=0 -> 1 edge, E=7 -> 8 edges).
REQ-020 S=1 with F=0 SHALL yield D = 12'h000 (no negative zero).
REQ-021 In DONE, D and out_valid=1 SHALL hold stable until an edge with out_ready=1.
- That edge: out_valid <= 0; state -> IDLE.
- D keeps its last value.
REQ-022 in_valid SHALL be ignored while state is SHIFT or DONE.
- A new word is accepted no earlier than the edge after the DONE->IDLE edge.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 mag SHALL be 11 bits; a shift SHALL never lose a set bit (F<=15, E<=7).
REQ-025 The negation SHALL be 12-bit two's complement, and the result SHALL wrap modulo 2^12.

Reset
REQ-026 While rst_n=0, the block SHALL immediately (asynchronously) force:
- state=IDLE, in_ready=1, out_valid=0
- D=12'h000, mag=0, cnt=0, sgn=0
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the conversion in progress.
- No out_valid pulse after rst_n returns to 1.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 The bench SHALL cover these scenarios:
- S=0,E=0,F=4'h5, out_ready=1 -> out_valid 1 edge after accept, D=12'h005, in_ready back to 1 the edge after.
- S=0,E=4,F=4'h8 -> out_valid 5 edges after accept, D=12'h080.
- S=1,E=7,F=4'hF -> out_valid 8 edges after accept, D=12'h880 (-1920).
- S=1,E=5,F=4'h0 -> out_valid 6 edges after accept, D=12'h000.
- S=0,E=2,F=4'h3, out_ready held 0 for 5 cycles; second word (S=1,E=1,F=1) driven with in_valid=1 throughout -> D stays 12'h00C, in_ready=0, out_valid=1. After out_ready=1: second word accepted only once in_ready=1, giving D=12'hFFE.
- rst_n pulsed low 2 cycles after accepting E=6 -> out_valid=0, D=12'h000, in_ready=1 asynchronously; no later out_valid without a new accept.
REQ-030 The bench SHALL exhaustively compare all 256 {S,E,F} combinations against a reference model.
- Check per word: D and exact E+1 latency.
- Check every cycle: one conversion in flight at most.
